// File: rtl/serdes_pkg.sv
// Types and helpers shared by the serializer/deserializer pair.
// Bit-order constants must agree with the PISO side of the link.
package serdes_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } sipo_state_t;

  localparam bit BIT_ORDER_MSB = 1'b1;
  localparam bit BIT_ORDER_LSB = 1'b0;

  // Bits needed to count 0..width inclusive.
  function automatic int unsigned CNT_W(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input side and word output side of the deserializer.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             serial_in;
  logic             serial_valid;
  logic             frame_start;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             frame_err;

  modport master (
    output serial_in, serial_valid, frame_start, out_ready,
    input  parallel_out, out_valid, overrun, frame_err
  );

  modport slave (
    input  serial_in, serial_valid, frame_start, out_ready,
    output parallel_out, out_valid, overrun, frame_err
  );

endinterface

// File: rtl/sipo_out_buf.sv
// One-word holding buffer with valid/ready handshake and sticky overrun.
module sipo_out_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             drain;

  // A drain on the same edge frees the slot for an incoming word.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    drain     = valid_q && out_ready;
    if (load_valid) begin
      if (!valid_q || drain) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = data_q;
  assign out_valid    = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: frame-aligned bit assembly feeding
// a one-word valid/ready output buffer.
module sipo_deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = BIT_ORDER_MSB
) (
  input logic                clk,
  input logic                rst,
  sipo_deserializer_if.slave bus
);

  localparam int unsigned CW = CNT_W(WIDTH);

  sipo_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;

  logic             start;
  logic             last_bit;
  logic             word_done;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shifted;

  // A frame_start bit always begins a fresh word from an empty register.
  always_comb begin
    start      = bus.serial_valid && bus.frame_start;
    shift_base = start ? '0 : shreg_q;
    if (MSB_FIRST == BIT_ORDER_MSB) begin
      shifted    = shift_base << 1;
      shifted[0] = bus.serial_in;
    end else begin
      shifted            = shift_base >> 1;
      shifted[WIDTH-1]   = bus.serial_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    last_bit    = 1'b0;
    if (bus.serial_valid && (start || state_q == SHIFT)) begin
      if (start && state_q == SHIFT && cnt_q != '0) begin
        frame_err_d = 1'b1;
      end
      last_bit = start ? (WIDTH == 1) : (cnt_q == CW'(WIDTH - 1));
      shreg_d  = shifted;
      if (last_bit) begin
        word_done = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else begin
        cnt_d   = start ? CW'(1) : cnt_q + CW'(1);
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.frame_err = frame_err_q;

  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (word_done),
    .load_data    (shifted),
    .out_ready    (bus.out_ready),
    .parallel_out (bus.parallel_out),
    .out_valid    (bus.out_valid),
    .overrun      (bus.overrun)
  );

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out deserializer that sits directly downstream of the PISO shift register and rebuilds its serial bit stream into WIDTH-bit words. Bits are accepted on a per-bit strobe, and each word is aligned by a frame-start marker on its first bit. Completed words are presented on a valid/ready output port with a one-word holding buffer. Overrun and framing errors are flagged.

## Interface
- WIDTH, 8: word width in bits; legal range 1 to 64.
- MSB_FIRST, 1: 1 = the first received bit lands in parallel_out[WIDTH-1]; 0 = the first received bit lands in parallel_out[0].

- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- serial_in  in  1  data bit, sampled only when serial_valid=1.
- serial_valid  in  1  bit strobe; one bit is accepted per edge while it is high.
- frame_start  in  1  qualified by serial_valid; marks the current bit as bit 0 of a word.
- parallel_out  out  WIDTH  assembled word; stable while out_valid=1.
- out_valid  out  1  a word is held in the output buffer.
- out_ready  in  1  consumer accepts the word on an edge where out_valid and out_ready are both 1.
- overrun  out  1  sticky; a completed word was dropped because the buffer was full.
- frame_err  out  1  one-cycle pulse; a frame_start arrived while a partial word was in progress.

## Operation
- FSM states:
  - IDLE: ignores serial_valid while frame_start=0. A frame_start bit loads bit 0, sets cnt=1, and moves to SHIFT. If WIDTH=1, the word completes instead and the FSM stays in IDLE.
  - SHIFT: each accepted bit is shifted in and cnt increments. When the bit at cnt=WIDTH-1 is accepted, the word completes, cnt clears and the FSM returns to IDLE.
- Shifting order:
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1.
- frame_start during SHIFT with cnt>0:
  - The partial word is discarded and the current bit becomes bit 0 (cnt=1).
  - frame_err pulses for one cycle. The FSM stays in SHIFT, or goes to IDLE with a completed word if WIDTH=1.
- Word completion:
  - Buffer empty, or being drained on the same edge (out_valid and out_ready both 1): the word loads and out_valid is 1 after the edge. Simultaneous drain and load is not an overrun.
  - Buffer full and not draining: the new word is dropped, the held word is unchanged, and overrun is set.
- overrun stays set until rst.
- The shift register is only updated by accepted bits. A gap in serial_valid holds all state.
- cnt width is clog2(WIDTH+1). No wrap occurs; the counter always clears on completion.

## Timing
- Reset values: parallel_out=0, out_valid=0, overrun=0, frame_err=0, FSM=IDLE, cnt=0, shift register=0.
- rst asserted mid-word or mid-handshake clears everything immediately. The partial word and any held word are lost.
- Latency: out_valid rises in the cycle after the edge that samples the last bit. At one bit per cycle, an uninterrupted word takes WIDTH+1 cycles from its first bit to out_valid.
- out_valid falls in the cycle after a handshake edge unless a new word loads on that same edge.
- frame_err is registered: it is high for exactly the one cycle after the offending edge.
- Throughput: one word every WIDTH cycles with out_ready held at 1. There are no bubbles.

## Structure
- Shared package serdes_pkg holds:
  - typedef enum {IDLE, SHIFT} sipo_state_t;
  - a CNT_W(width) helper computing clog2(width+1).
  - the bit-order constants BIT_ORDER_MSB=1 and BIT_ORDER_LSB=0, shared with the PISO side.
- Sub-module sipo_out_buf holds the WIDTH-wide output register with valid/ready and overrun logic. The top level contains the FSM, counter and shift register.

## Test plan
- MSB_FIRST=1, out_ready=1: send bits 1,1,0,1,1,0,1,0 on consecutive cycles with frame_start on the first bit. Required: parallel_out=8'hDA and out_valid=1 in the cycle after the 8th bit, for one cycle.
- MSB_FIRST=0, same bit sequence. Required: parallel_out=8'h5B.
- Backpressure: out_ready=0, send 8'hDA then 8'h3C. Required: parallel_out stays 8'hDA and overrun=1. Then raise out_ready; the handshake completes and out_valid drops.
- Drain and load on the same edge: out_ready rises on the edge that completes the second word 8'h3C. Required: overrun=0, out_valid stays 1, parallel_out=8'h3C.
- Restart: after 3 bits of a word, assert frame_start and send 8'hA5. Required: frame_err pulses once, output=8'hA5.
- Reset mid-word after 5 bits, with serial_valid toggling in gaps. Required: all outputs are 0 immediately, and the next framed 8'h81 is received correctly.
